// File: rtl/mbscore_wb_pkg.sv
// rtl/mbscore_wb_pkg.sv - shared types and constants for the writeback arbiter
package mbscore_wb_pkg;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'd0,
        SRC_LINK = 2'd1,
        SRC_ALU  = 2'd2
    } wb_src_e;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_DRAIN = 2'd1,
        WB_SAVE  = 2'd2
    } wb_state_e;

    localparam int unsigned WB_LINK_REG  = 31;
    localparam int unsigned WB_LUI_SHIFT = 16;
    // Wide enough for any STARVE_LIMIT in 1..15.
    localparam int unsigned WB_WAIT_W    = 4;

endpackage

// File: rtl/mbscore_wb_skid.sv
// rtl/mbscore_wb_skid.sv - one-entry valid/ready request buffer with addr/data
module mbscore_wb_skid #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  accept_en,
    input  logic                  drain,
    output logic                  ent_valid,
    output logic [ADDR_WIDTH-1:0] ent_addr,
    output logic [DATA_WIDTH-1:0] ent_data
);

    logic load;

    // A draining entry frees the slot in the same cycle, so a new one can land.
    assign in_ready = accept_en && (!ent_valid || drain);
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= 1'b0;
            ent_addr  <= '0;
            ent_data  <= '0;
        end else if (load) begin
            ent_valid <= 1'b1;
            ent_addr  <= in_addr;
            ent_data  <= in_data;
        end else if (drain) begin
            ent_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mbscore_wb_arbiter.sv
// rtl/mbscore_wb_arbiter.sv - GR writeback arbiter with interrupt-entry sequencing
module mbscore_wb_arbiter
    import mbscore_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LINK_REG       = WB_LINK_REG,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    input  logic                      alu_lui,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    input  logic                      link_valid,
    output logic                      link_ready,
    input  logic [DATA_WIDTH-1:0]     link_pc,
    input  logic                      intr_req,
    input  logic [DATA_WIDTH-1:0]     intr_pc,
    input  logic                      int_dis,
    output logic                      intr_ack,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      spr_epc_we,
    output logic [DATA_WIDTH-1:0]     spr_epc_data,
    input  logic [REG_ADDR_WIDTH-1:0] chk_addr_a,
    input  logic [REG_ADDR_WIDTH-1:0] chk_addr_b,
    output logic                      hazard_a,
    output logic                      hazard_b
);

    localparam logic [1:0] ST_IDLE  = WB_IDLE;
    localparam logic [1:0] ST_DRAIN = WB_DRAIN;
    localparam logic [1:0] ST_SAVE  = WB_SAVE;

    localparam logic [REG_ADDR_WIDTH-1:0] LINK_ADDR  = REG_ADDR_WIDTH'(LINK_REG);
    localparam logic [WB_WAIT_W-1:0]      STARVE_MAX = WB_WAIT_W'(STARVE_LIMIT);

    logic [1:0]                state;
    logic [DATA_WIDTH-1:0]     epc_q;
    logic [WB_WAIT_W-1:0]      alu_wait;
    logic                      accept_en;

    logic                      mem_ev,  link_ev,  alu_ev;
    logic [REG_ADDR_WIDTH-1:0] mem_ea,  link_ea,  alu_ea;
    logic [DATA_WIDTH-1:0]     mem_ed,  link_ed,  alu_ed;
    logic [DATA_WIDTH-1:0]     link_wdata, alu_wdata;

    wb_src_e                   grant_src;
    logic                      grant_any, grant_mem, grant_link, grant_alu;
    logic                      alu_starved;
    logic [REG_ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0]     grant_data;
    logic                      drained;

    // ALU and link are held off while draining; loads must keep flowing.
    assign accept_en  = (state != ST_DRAIN);
    assign link_wdata = link_pc + DATA_WIDTH'(4);
    assign alu_wdata  = alu_lui ? (alu_data << WB_LUI_SHIFT) : alu_data;

    mbscore_wb_skid #(.ADDR_WIDTH(REG_ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mem_valid),
        .in_ready  (mem_ready),
        .in_addr   (mem_addr),
        .in_data   (mem_data),
        .accept_en (1'b1),
        .drain     (grant_mem),
        .ent_valid (mem_ev),
        .ent_addr  (mem_ea),
        .ent_data  (mem_ed)
    );

    mbscore_wb_skid #(.ADDR_WIDTH(REG_ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_link_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (link_valid),
        .in_ready  (link_ready),
        .in_addr   (LINK_ADDR),
        .in_data   (link_wdata),
        .accept_en (accept_en),
        .drain     (grant_link),
        .ent_valid (link_ev),
        .ent_addr  (link_ea),
        .ent_data  (link_ed)
    );

    mbscore_wb_skid #(.ADDR_WIDTH(REG_ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_alu_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (alu_valid),
        .in_ready  (alu_ready),
        .in_addr   (alu_addr),
        .in_data   (alu_wdata),
        .accept_en (accept_en),
        .drain     (grant_alu),
        .ent_valid (alu_ev),
        .ent_addr  (alu_ea),
        .ent_data  (alu_ed)
    );

    assign alu_starved = alu_ev && (alu_wait >= STARVE_MAX);

    always_comb begin
        grant_src = SRC_ALU;
        if (alu_starved) begin
            grant_src = SRC_ALU;
        end else if (mem_ev) begin
            grant_src = SRC_MEM;
        end else if (link_ev) begin
            grant_src = SRC_LINK;
        end
        grant_any  = mem_ev || link_ev || alu_ev;
        grant_mem  = grant_any && (grant_src == SRC_MEM);
        grant_link = grant_any && (grant_src == SRC_LINK);
        grant_alu  = grant_any && (grant_src == SRC_ALU);
        case (grant_src)
            SRC_MEM: begin
                grant_addr = mem_ea;
                grant_data = mem_ed;
            end
            SRC_LINK: begin
                grant_addr = link_ea;
                grant_data = link_ed;
            end
            default: begin
                grant_addr = alu_ea;
                grant_data = alu_ed;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_wait <= '0;
        end else if (grant_alu) begin
            alu_wait <= '0;
        end else if (alu_ev && (alu_wait != '1)) begin
            alu_wait <= alu_wait + 1'b1;
        end
    end

    // Writes to r0 still consume their buffer but never reach the file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_any && (grant_addr != '0);
            if (grant_any) begin
                rf_waddr <= grant_addr;
                rf_wdata <= grant_data;
            end
        end
    end

    assign drained = !(mem_ev || link_ev || alu_ev) && !rf_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            epc_q      <= '0;
            spr_epc_we <= 1'b0;
            intr_ack   <= 1'b0;
        end else begin
            spr_epc_we <= 1'b0;
            intr_ack   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (intr_req && !int_dis) begin
                        state <= ST_DRAIN;
                        epc_q <= intr_pc;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state      <= ST_SAVE;
                        spr_epc_we <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    state    <= ST_IDLE;
                    intr_ack <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign spr_epc_data = epc_q;

    assign hazard_a = (chk_addr_a != '0) &&
                      ((mem_ev  && (mem_ea  == chk_addr_a)) ||
                       (link_ev && (link_ea == chk_addr_a)) ||
                       (alu_ev  && (alu_ea  == chk_addr_a)) ||
                       (rf_we   && (rf_waddr == chk_addr_a)));

    assign hazard_b = (chk_addr_b != '0) &&
                      ((mem_ev  && (mem_ea  == chk_addr_b)) ||
                       (link_ev && (link_ea == chk_addr_b)) ||
                       (alu_ev  && (alu_ea  == chk_addr_b)) ||
                       (rf_we   && (rf_waddr == chk_addr_b)));

endmodule

// File: tb/tb_mbscore_wb_arbiter.sv
// tb/tb_mbscore_wb_arbiter.sv - self-checking bench for mbscore_wb_arbiter
module tb_mbscore_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready, alu_lui;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          link_valid, link_ready;
    logic [DW-1:0] link_pc;
    logic          intr_req, int_dis, intr_ack;
    logic [DW-1:0] intr_pc;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          spr_epc_we;
    logic [DW-1:0] spr_epc_data;
    logic [AW-1:0] chk_addr_a, chk_addr_b;
    logic          hazard_a, hazard_b;

    always #5 clk = ~clk;

    mbscore_wb_arbiter #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .LINK_REG(31), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
        .alu_data(alu_data), .alu_lui(alu_lui),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .link_valid(link_valid), .link_ready(link_ready), .link_pc(link_pc),
        .intr_req(intr_req), .intr_pc(intr_pc), .int_dis(int_dis), .intr_ack(intr_ack),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .spr_epc_we(spr_epc_we), .spr_epc_data(spr_epc_data),
        .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference: pending request per source (0 mem, 1 link, 2 alu), plus write/interrupt state.
    logic          m_v [3];
    logic [AW-1:0] m_a [3];
    logic [DW-1:0] m_d [3];
    int            m_wait;
    logic          m_rf_we;
    logic [AW-1:0] m_rf_waddr;
    logic [DW-1:0] m_rf_wdata;
    int            m_mode;   // 0 normal, 1 waiting for drain, 2 saving
    logic [DW-1:0] m_epc;
    logic          m_spr_we, m_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_pick();
        if (m_v[2] && m_wait >= SL) return 2;
        for (int i = 0; i < 3; i++) if (m_v[i]) return i;
        return -1;
    endfunction

    function automatic logic m_ready(input int i);
        if (i != 0 && m_mode == 1) return 1'b0;
        return !m_v[i] || (m_pick() == i);
    endfunction

    function automatic logic m_hazard(input logic [AW-1:0] x);
        if (x == 0) return 1'b0;
        for (int i = 0; i < 3; i++) if (m_v[i] && m_a[i] == x) return 1'b1;
        return m_rf_we && (m_rf_waddr == x);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0; m_a[i] = '0; m_d[i] = '0;
        end
        m_wait = 0; m_rf_we = 1'b0; m_rf_waddr = '0; m_rf_wdata = '0;
        m_mode = 0; m_epc = '0; m_spr_we = 1'b0; m_ack = 1'b0;
    endtask

    task automatic model_edge();
        int            g;
        logic          rdy [3];
        logic          iv  [3];
        logic [AW-1:0] ia  [3];
        logic [DW-1:0] id  [3];
        logic          empty;
        g = m_pick();
        for (int i = 0; i < 3; i++) rdy[i] = m_ready(i);
        empty = !(m_v[0] || m_v[1] || m_v[2]) && !m_rf_we;
        iv[0] = mem_valid;  ia[0] = mem_addr; id[0] = mem_data;
        iv[1] = link_valid; ia[1] = 5'd31;    id[1] = link_pc + 32'd4;
        iv[2] = alu_valid;  ia[2] = alu_addr;
        id[2] = alu_lui ? {alu_data[15:0], 16'h0000} : alu_data;
        if (g >= 0) begin
            m_rf_we = (m_a[g] != 0); m_rf_waddr = m_a[g]; m_rf_wdata = m_d[g];
        end else begin
            m_rf_we = 1'b0;
        end
        if (g == 2) m_wait = 0;
        else if (m_v[2] && m_wait < 15) m_wait++;
        for (int i = 0; i < 3; i++) begin
            if (iv[i] && rdy[i]) begin
                m_v[i] = 1'b1; m_a[i] = ia[i]; m_d[i] = id[i];
            end else if (g == i) begin
                m_v[i] = 1'b0;
            end
        end
        m_spr_we = 1'b0;
        m_ack    = 1'b0;
        if (m_mode == 0) begin
            if (intr_req && !int_dis) begin m_mode = 1; m_epc = intr_pc; end
        end else if (m_mode == 1) begin
            if (empty) begin m_mode = 2; m_spr_we = 1'b1; end
        end else begin
            m_mode = 0; m_ack = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("mem_ready",  mem_ready,  m_ready(0));
        chk("link_ready", link_ready, m_ready(1));
        chk("alu_ready",  alu_ready,  m_ready(2));
        chk("rf_we",      rf_we,      m_rf_we);
        if (m_rf_we) begin
            chk("rf_waddr", rf_waddr, m_rf_waddr);
            chk("rf_wdata", rf_wdata, m_rf_wdata);
        end
        chk("spr_epc_we", spr_epc_we, m_spr_we);
        if (m_spr_we) chk("spr_epc_data", spr_epc_data, m_epc);
        chk("intr_ack",   intr_ack,   m_ack);
        chk("hazard_a",   hazard_a,   m_hazard(chk_addr_a));
        chk("hazard_b",   hazard_b,   m_hazard(chk_addr_b));
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        alu_valid = 0; alu_addr = '0; alu_data = '0; alu_lui = 0;
        mem_valid = 0; mem_addr = '0; mem_data = '0;
        link_valid = 0; link_pc = '0;
        intr_req = 0; intr_pc = '0; int_dis = 0;
        chk_addr_a = '0; chk_addr_b = '0;
    endtask

    task automatic starve_round(input logic [AW-1:0] aa, output int n);
        alu_valid = 1; alu_addr = aa; alu_data = 32'hC0DE0000 | 32'(aa); alu_lui = 0;
        mem_valid = 1; mem_addr = 5'd20; mem_data = 32'h1;
        step();
        alu_valid = 0;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            mem_addr = 5'(10 + k); mem_data = 32'(k);
            step();
            if (rf_we && rf_waddr == aa) begin n = k; break; end
        end
    endtask

    initial begin
        int   n;
        logic seen;
        rst = 1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        chk("reset_mem_ready", mem_ready, 1'b1);
        rst = 0;

        // ALU LUI write
        alu_valid = 1; alu_addr = 5'd5; alu_data = 32'h1234; alu_lui = 1; chk_addr_a = 5'd5;
        step();
        #1 chk("lui_hazard_buffered", hazard_a, 1'b1);
        alu_valid = 0;
        step();
        chk("lui_we", rf_we, 1'b1);
        chk("lui_waddr", rf_waddr, 5'd5);
        chk("lui_wdata", rf_wdata, 32'h12340000);
        step();

        // mem, link, alu simultaneously
        mem_valid = 1; mem_addr = 5'd3; mem_data = 32'hAAAA;
        link_valid = 1; link_pc = 32'h100;
        alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h77; alu_lui = 0;
        step();
        clear_inputs();
        step();
        chk("order1_addr", rf_waddr, 5'd3);
        step();
        chk("order2_addr", rf_waddr, 5'd31);
        chk("order2_data", rf_wdata, 32'h104);
        step();
        chk("order3_addr", rf_waddr, 5'd7);
        step();

        // Starvation guard, twice in a row to show the wait count restarts
        starve_round(5'd9, n);
        chk("starve_cycles_1", n, 5);
        starve_round(5'd8, n);
        chk("starve_cycles_2", n, 5);
        clear_inputs();
        repeat (3) step();

        // Write to r0
        alu_valid = 1; alu_addr = 5'd0; alu_data = 32'h55; chk_addr_a = 5'd0;
        step();
        alu_valid = 0;
        step();
        chk("r0_we", rf_we, 1'b0);
        chk("r0_hazard", hazard_a, 1'b0);
        chk("r0_ready", alu_ready, 1'b1);
        step();

        // Interrupt entry with the ALU buffer filling at the same edge
        alu_valid = 1; alu_addr = 5'd12; alu_data = 32'hBEEF;
        intr_req = 1; intr_pc = 32'h40;
        step();
        #1;
        chk("drain_alu_ready", alu_ready, 1'b0);
        chk("drain_link_ready", link_ready, 1'b0);
        chk("drain_mem_ready", mem_ready, 1'b1);
        alu_addr = 5'd13; intr_pc = 32'h99;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            intr_req = 0;
            if (spr_epc_we) begin seen = 1; break; end
        end
        chk("epc_we_seen", seen, 1'b1);
        chk("epc_data", spr_epc_data, 32'h40);
        step();
        chk("intr_ack", intr_ack, 1'b1);
        alu_valid = 0;
        repeat (2) step();

        // Masked interrupt is ignored
        int_dis = 1; intr_req = 1; intr_pc = 32'h80;
        step();
        intr_req = 0; int_dis = 0;
        #1 chk("masked_link_ready", link_ready, 1'b1);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (spr_epc_we) seen = 1;
        end
        chk("masked_no_epc", seen, 1'b0);

        // Reset while draining with all buffers full
        mem_valid = 1; mem_addr = 5'd1; link_valid = 1; link_pc = 32'h200;
        alu_valid = 1; alu_addr = 5'd2; intr_req = 1; intr_pc = 32'h44;
        step();
        clear_inputs();
        rst = 1;
        model_reset();
        #1;
        check_outputs();
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (spr_epc_we || rf_we) seen = 1;
        end
        chk("rst_no_activity", seen, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            mem_valid  = ($urandom_range(0, 1) == 1);
            mem_addr   = 5'($urandom_range(0, 31));
            mem_data   = $urandom;
            link_valid = ($urandom_range(0, 2) == 0);
            link_pc    = $urandom;
            alu_valid  = ($urandom_range(0, 1) == 1);
            alu_addr   = 5'($urandom_range(0, 31));
            alu_data   = $urandom;
            alu_lui    = ($urandom_range(0, 3) == 0);
            intr_req   = ($urandom_range(0, 19) == 0);
            int_dis    = ($urandom_range(0, 3) == 0);
            intr_pc    = $urandom;
            chk_addr_a = 5'($urandom_range(0, 31));
            chk_addr_b = ($urandom_range(0, 1) == 1) ? m_rf_waddr : 5'($urandom_range(0, 31));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
